// File: rtl/raycast_pkg.sv
// raycast_pkg: column entry format, RGB565 palette and default screen geometry for the wall column buffer
package raycast_pkg;
  localparam int DEF_SCREEN_WIDTH = 320;
  localparam int DEF_SCREEN_HEIGHT = 240;
  typedef logic [15:0] rgb565_t;
  typedef struct packed {
    logic [7:0] lh;
    logic       side;
    logic [3:0] map;
    logic [4:0] u;
  } col_entry_t;
  localparam rgb565_t ERR_COLOR = 16'hF81F;
  localparam rgb565_t PALETTE [16] = '{
    16'h0000, 16'h8410, 16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'h07FF, 16'hFD20,
    16'h8000, 16'h0400, 16'h0010, 16'h8400, 16'h0410, 16'h8010, 16'hC618, 16'hFFFF
  };
  function automatic rgb565_t shade(input rgb565_t c);
    return {1'b0, c[15:12], 1'b0, c[10:6], 1'b0, c[4:1]};
  endfunction
endpackage

// File: rtl/wall_column_buffer_if.sv
// wall_column_buffer_if: DDA result write port, pixel read port and frame handshake of the wall column buffer
interface wall_column_buffer_if;
  logic        dda_valid_in;
  logic [8:0]  hcount_ray_in;
  logic [7:0]  lineHeight_in;
  logic        wallType_in;
  logic [3:0]  mapData_in;
  logic [15:0] wallX_in;
  logic        new_frame_in;
  logic        pix_valid_in;
  logic [8:0]  hcount_in;
  logic [7:0]  vcount_in;
  logic [15:0] color_out;
  logic        color_valid_out;
  logic        frame_start_out;
  logic        frame_ready_out;
  modport master (
    output dda_valid_in, hcount_ray_in, lineHeight_in, wallType_in, mapData_in, wallX_in,
    output new_frame_in, pix_valid_in, hcount_in, vcount_in,
    input  color_out, color_valid_out, frame_start_out, frame_ready_out
  );
  modport slave (
    input  dda_valid_in, hcount_ray_in, lineHeight_in, wallType_in, mapData_in, wallX_in,
    input  new_frame_in, pix_valid_in, hcount_in, vcount_in,
    output color_out, color_valid_out, frame_start_out, frame_ready_out
  );
endinterface

// File: rtl/column_bank_ram.sv
// column_bank_ram: one column bank, single write port and one registered read port
module column_bank_ram
  import raycast_pkg::*;
#(
  parameter int DEPTH = DEF_SCREEN_WIDTH
) (
  input  logic       clk,
  input  logic       we,
  input  logic [8:0] waddr,
  input  col_entry_t wdata,
  input  logic [8:0] raddr,
  output col_entry_t rdata
);
  col_entry_t mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata <= mem_q[raddr];
  end
endmodule

// File: rtl/wall_column_buffer.sv
// wall_column_buffer: double-buffered per-column wall store with tear-free bank swap and 2-cycle pixel colour lookup.
// Define WALL_COLUMN_BUFFER_SHADE_EN to halve each channel of Y-side wall pixels.
module wall_column_buffer
  import raycast_pkg::*;
#(
  parameter int      SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int      SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter rgb565_t CEIL_COLOR    = 16'h18C3,
  parameter rgb565_t FLOOR_COLOR   = 16'h4208
) (
  input logic pixel_clk_in,
  input logic rst_in,
  wall_column_buffer_if.slave bus
);
  localparam logic [8:0] W9    = 9'(SCREEN_WIDTH);
  localparam logic [8:0] LAST9 = 9'(SCREEN_WIDTH - 1);
  localparam logic [8:0] H9    = 9'(SCREEN_HEIGHT);
  localparam logic [7:0] H8    = 8'(SCREEN_HEIGHT);
  localparam logic [7:0] HALF8 = 8'(SCREEN_HEIGHT / 2);
  logic       rd_bank_q, rd_bank_d, wr_done_q, wr_done_d, pend_q;
  logic       frame_start_q, frame_start_d, frame_ready_q, frame_ready_d;
  logic       valid_s0_q, valid_s0_d, ok_s0_q, ok_s0_d, sel_s0_q, sel_s0_d;
  logic [7:0] v_s0_q, v_s0_d;
  rgb565_t    color_q, color_d, wall_c;
  logic       cvalid_q, cvalid_d;
  logic       wr_ok, last_wr, swap, in_wall;
  logic [8:0] raddr, y_start, y_end;
  col_entry_t wr_entry, rd0, rd1, e;
  logic       unused_bits;
  column_bank_ram #(.DEPTH(SCREEN_WIDTH)) u_bank0 (
    .clk(pixel_clk_in), .we(wr_ok && rd_bank_q), .waddr(bus.hcount_ray_in),
    .wdata(wr_entry), .raddr(raddr), .rdata(rd0)
  );
  column_bank_ram #(.DEPTH(SCREEN_WIDTH)) u_bank1 (
    .clk(pixel_clk_in), .we(wr_ok && !rd_bank_q), .waddr(bus.hcount_ray_in),
    .wdata(wr_entry), .raddr(raddr), .rdata(rd1)
  );
  assign unused_bits = ^{e.u, e.side, bus.wallX_in[15:8], bus.wallX_in[2:0]};
  always_comb begin
    wr_ok = bus.dda_valid_in && bus.hcount_ray_in < W9;
    wr_entry = {(bus.lineHeight_in > H8 ? H8 : bus.lineHeight_in), bus.wallType_in,
                bus.mapData_in, bus.wallX_in[7:3]};
    last_wr = wr_ok && bus.hcount_ray_in == LAST9;
    // the last-column write in a new_frame cycle commits before the swap decision
    swap = bus.new_frame_in && (wr_done_q || last_wr);
    rd_bank_d = rd_bank_q ^ swap;
    wr_done_d = !swap && (wr_done_q || last_wr);
    frame_start_d = pend_q || swap;
    frame_ready_d = frame_ready_q || swap;
    raddr = bus.hcount_in < W9 ? bus.hcount_in : 9'd0;
    valid_s0_d = bus.pix_valid_in;
    ok_s0_d = bus.hcount_in < W9 && bus.vcount_in < H8;
    v_s0_d = bus.vcount_in;
    sel_s0_d = rd_bank_q;
    e = sel_s0_q ? rd1 : rd0;
    y_start = (H9 - {1'b0, e.lh}) >> 1;
    y_end = y_start + {1'b0, e.lh};
    in_wall = {1'b0, v_s0_q} >= y_start && {1'b0, v_s0_q} < y_end;
`ifdef WALL_COLUMN_BUFFER_SHADE_EN
    wall_c = e.map == 4'd0 ? ERR_COLOR : e.side ? shade(PALETTE[e.map]) : PALETTE[e.map];
`else
    wall_c = e.map == 4'd0 ? ERR_COLOR : PALETTE[e.map];
`endif
    color_d = (valid_s0_q && ok_s0_q && frame_ready_q) ?
              (in_wall ? wall_c : v_s0_q < HALF8 ? CEIL_COLOR : FLOOR_COLOR) : 16'h0000;
    cvalid_d = valid_s0_q;
  end
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      rd_bank_q <= 1'b0;
      wr_done_q <= 1'b0;
      pend_q <= 1'b1;
      frame_start_q <= 1'b0;
      frame_ready_q <= 1'b0;
      valid_s0_q <= 1'b0;
      ok_s0_q <= 1'b0;
      sel_s0_q <= 1'b0;
      v_s0_q <= 8'd0;
      color_q <= 16'h0000;
      cvalid_q <= 1'b0;
    end else begin
      rd_bank_q <= rd_bank_d;
      wr_done_q <= wr_done_d;
      pend_q <= 1'b0;
      frame_start_q <= frame_start_d;
      frame_ready_q <= frame_ready_d;
      valid_s0_q <= valid_s0_d;
      ok_s0_q <= ok_s0_d;
      sel_s0_q <= sel_s0_d;
      v_s0_q <= v_s0_d;
      color_q <= color_d;
      cvalid_q <= cvalid_d;
    end
  end
  assign bus.color_out = color_q;
  assign bus.color_valid_out = cvalid_q;
  assign bus.frame_start_out = frame_start_q;
  assign bus.frame_ready_out = frame_ready_q;
endmodule

// File: tb/tb_wall_column_buffer.sv
// tb_wall_column_buffer: table vectors, directed swap/boundary sequences and random traffic against a frame-level model
module tb_wall_column_buffer;
`ifdef WALL_COLUMN_BUFFER_SHADE_EN
  localparam bit SHADE = 1'b1;
`else
  localparam bit SHADE = 1'b0;
`endif
  localparam logic [15:0] PAL [16] = '{
    16'h0000, 16'h8410, 16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'h07FF, 16'hFD20,
    16'h8000, 16'h0400, 16'h0010, 16'h8400, 16'h0410, 16'h8010, 16'hC618, 16'hFFFF
  };
  localparam logic [15:0] CEIL = 16'h18C3, FLOOR = 16'h4208;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  wall_column_buffer_if bus();
  wall_column_buffer dut (.pixel_clk_in(clk), .rst_in(rst), .bus(bus));
  typedef struct {int lh; bit side; int map; bit k;} ent_t;
  typedef struct {int h; int v; logic [15:0] exp; string name;} vec_t;
  ent_t mb [2][320];
  int m_rd;
  bit m_done, m_ready, m_start, m_pend;
  bit p_v, p_ok, p_k, e_v, e_k;
  logic [15:0] p_raw, e_c;
  int checks = 0, errors = 0;
  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask
  function automatic logic [15:0] ref_color(ent_t e, int v);
    int top = (240 - e.lh) / 2;
    int r, g, b;
    logic [15:0] c;
    if (v >= top && v < top + e.lh) begin
      if (e.map == 0) return 16'hF81F;
      c = PAL[e.map];
      if (SHADE && e.side) begin
        r = int'(c[15:11]) / 2;
        g = int'(c[10:5]) / 2;
        b = int'(c[4:0]) / 2;
        c = 16'(r * 2048 + g * 32 + b);
      end
      return c;
    end
    return v < 120 ? CEIL : FLOOR;
  endfunction
  task automatic tick();
    int h, v;
    bit nv, nok, nk, last, sw;
    logic [15:0] nraw;
    ent_t e;
    h = int'(bus.hcount_in);
    v = int'(bus.vcount_in);
    nv = bus.pix_valid_in;
    nok = h < 320 && v < 240;
    e = mb[m_rd][h < 320 ? h : 0];
    nraw = ref_color(e, v);
    nk = e.k || !nok;
    if (rst) begin
      m_rd = 0; m_done = 0; m_ready = 0; m_pend = 1; m_start = 0;
      p_v = 0; e_v = 0; e_c = 16'h0; e_k = 1;
    end else begin
      e_v = p_v;
      e_k = p_k || !(p_v && p_ok && m_ready);
      e_c = (p_v && p_ok && m_ready) ? p_raw : 16'h0;
      p_v = nv; p_ok = nok; p_raw = nraw; p_k = nk;
      last = 0;
      if (bus.dda_valid_in && bus.hcount_ray_in < 320) begin
        mb[1 - m_rd][bus.hcount_ray_in] = '{lh: bus.lineHeight_in > 240 ? 240 : int'(bus.lineHeight_in),
                                            side: bus.wallType_in, map: int'(bus.mapData_in), k: 1'b1};
        last = bus.hcount_ray_in == 319;
      end
      m_done = m_done || last;
      sw = bus.new_frame_in && m_done;
      m_start = m_pend || sw;
      m_pend = 0;
      if (sw) begin m_rd = 1 - m_rd; m_done = 0; m_ready = 1; end
    end
    @(posedge clk);
    #1;
    chk("color_valid", bus.color_valid_out, e_v);
    chk("frame_start", bus.frame_start_out, m_start);
    chk("frame_ready", bus.frame_ready_out, m_ready);
    if (e_k) chk("color", bus.color_out, e_c);
    bus.dda_valid_in = 0;
    bus.new_frame_in = 0;
    bus.pix_valid_in = 0;
  endtask
  task automatic wr(int c, int lh, bit side, int map, bit nf);
    bus.dda_valid_in = 1;
    bus.hcount_ray_in = 9'(c);
    bus.lineHeight_in = 8'(lh);
    bus.wallType_in = side;
    bus.mapData_in = 4'(map);
    bus.wallX_in = 16'($urandom);
    bus.new_frame_in = nf;
    tick();
  endtask
  task automatic rd(int h, int v, output logic [15:0] col);
    bus.pix_valid_in = 1;
    bus.hcount_in = 9'(h);
    bus.vcount_in = 8'(v);
    tick();
    tick();
    col = bus.color_out;
  endtask
  vec_t tab1 [9], tab2 [11];
  logic [15:0] col;
  initial begin
    bus.dda_valid_in = 0; bus.hcount_ray_in = 0; bus.lineHeight_in = 0; bus.wallType_in = 0;
    bus.mapData_in = 0; bus.wallX_in = 0; bus.new_frame_in = 0; bus.pix_valid_in = 0;
    bus.hcount_in = 0; bus.vcount_in = 0;
    tab1 = '{'{0, 70, 16'hF800, "wall_top"}, '{0, 69, CEIL, "above_wall"},
             '{0, 170, FLOOR, "below_wall"}, '{0, 169, 16'hF800, "wall_bottom"},
             '{319, 120, 16'hF800, "last_col"}, '{320, 100, 16'h0000, "h_range"},
             '{10, 240, 16'h0000, "v_range"}, '{5, 0, CEIL, "ceil_row0"}, '{5, 239, FLOOR, "floor_row239"}};
    tab2 = '{'{319, 120, 16'h07E0, "same_cycle_swap"}, '{5, 0, 16'h001F, "tall_top"},
             '{5, 239, 16'h001F, "tall_bottom"}, '{6, 0, CEIL, "zero_lh_ceil"},
             '{6, 119, CEIL, "zero_lh_mid"}, '{6, 120, FLOOR, "zero_lh_floor"},
             '{7, 120, 16'hF81F, "map0_err"}, '{7, 0, CEIL, "map0_ceil"},
             '{8, 100, SHADE ? 16'h7BEF : 16'hFFFF, "side_shade"}, '{0, 120, 16'h07E0, "col0"},
             '{400, 120, 16'h0000, "h400_read"}};
    repeat (3) tick();
    chk("rst_color", bus.color_out, 16'h0);
    chk("rst_valid", bus.color_valid_out, 16'h0);
    chk("rst_start", bus.frame_start_out, 16'h0);
    chk("rst_ready", bus.frame_ready_out, 16'h0);
    rst = 0;
    bus.pix_valid_in = 1; bus.hcount_in = 9'd10; bus.vcount_in = 8'd5;
    tick();
    chk("first_start", bus.frame_start_out, 16'h1);
    tick();
    chk("first_valid", bus.color_valid_out, 16'h1);
    chk("first_color", bus.color_out, 16'h0);
    chk("first_ready", bus.frame_ready_out, 16'h0);
    chk("first_start_once", bus.frame_start_out, 16'h0);
    for (int c = 0; c < 320; c++) wr(c, 100, 0, 2, 0);
    bus.new_frame_in = 1;
    tick();
    chk("fill_swap_start", bus.frame_start_out, 16'h1);
    chk("fill_swap_ready", bus.frame_ready_out, 16'h1);
    for (int i = 0; i < 9; i++) begin
      rd(tab1[i].h, tab1[i].v, col);
      chk(tab1[i].name, col, tab1[i].exp);
    end
    for (int c = 0; c < 319; c++)
      wr(c, c == 5 ? 255 : c == 6 ? 0 : c == 8 ? 240 : 100, c == 8,
         c == 5 ? 4 : c == 7 ? 0 : c == 8 ? 15 : 3, 0);
    wr(400, 240, 1, 15, 1);
    chk("h400_no_swap", bus.frame_start_out, 16'h0);
    wr(319, 100, 0, 3, 1);
    chk("same_cycle_start", bus.frame_start_out, 16'h1);
    for (int i = 0; i < 11; i++) begin
      rd(tab2[i].h, tab2[i].v, col);
      chk(tab2[i].name, col, tab2[i].exp);
    end
    for (int v = 0; v < 240; v++) begin
      rd(5, v, col);
      chk("tall_all_rows", col, 16'h001F);
    end
    for (int c = 0; c <= 200; c++) wr(c, 100, 0, 5, 0);
    bus.new_frame_in = 1;
    tick();
    chk("partial_no_start", bus.frame_start_out, 16'h0);
    rd(0, 120, col);
    chk("partial_prev_col0", col, 16'h07E0);
    rd(200, 120, col);
    chk("partial_prev_col200", col, 16'h07E0);
    for (int i = 0; i < 4000; i++) begin
      rst = (i >= 2000 && i < 2002);
      if ($urandom_range(0, 1) == 1) begin
        bus.dda_valid_in = 1;
        bus.hcount_ray_in = ($urandom_range(0, 7) == 0) ? 9'd319 : 9'($urandom_range(0, 339));
        bus.lineHeight_in = 8'($urandom);
        bus.wallType_in = 1'($urandom);
        bus.mapData_in = 4'($urandom_range(1, 15));
        bus.wallX_in = 16'($urandom);
      end
      bus.new_frame_in = $urandom_range(0, 39) == 0;
      bus.pix_valid_in = $urandom_range(0, 3) != 0;
      bus.hcount_in = 9'($urandom_range(0, 330));
      bus.vcount_in = 8'($urandom_range(0, 250));
      tick();
    end
    rst = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
